booth_mac_accum: RTL and testbench
==================================

Name: booth_mac_accum

Overview:
Downstream consumer of mult_booth_array. Accumulates a stream of signed 8x8 Booth products into one dot-product result per frame, with saturating arithmetic.
Input side is a valid/ready stream gated by the shared clock enable. Output side presents one result per frame and holds it until the consumer accepts it.

Parameters:
PROD_W, 16, width of the signed product input (matches p_o of the multiplier)
ACC_W, 20, width of the signed accumulator and result (must be >= PROD_W)
MAX_TERMS, 16, maximum products per frame; reaching it auto-closes the frame

Ports:
clk_i  input  1  system clock, rising-edge
rst_ni  input  1  asynchronous active-low reset
ce_i  input  1  clock enable shared with the multiplier; gates the input side only
prod_i  input  PROD_W  signed two's-complement product
prod_valid_i  input  1  prod_i/last_i valid
prod_last_i  input  1  marks the final product of the current frame
prod_ready_o  output  1  block can accept a product this cycle
acc_o  output  ACC_W  signed frame result
acc_valid_o  output  1  result valid
acc_ready_i  input  1  consumer accepts the result
term_cnt_o  output  $clog2(MAX_TERMS+1)  number of products in the presented frame
ovf_o  output  1  sticky flag: saturation occurred at some point in the presented frame

Behaviour:
- Reset (async assert, sync release): state=IDLE; accumulator=0; count=0; ovf=0.
  - Outputs at reset: acc_o=0, acc_valid_o=0, term_cnt_o=0, ovf_o=0.
- prod_ready_o = ce_i && (state != HOLD). This is combinational.
- Accept condition: prod_valid_i && prod_ready_o.
- States:
  - IDLE: no terms accumulated.
  - ACCUM: one or more terms accumulated, frame still open.
  - HOLD: result presented on the output.
- Transitions:
  - On accept without close: acc <= sat(acc + sext(prod_i)); count++; ovf |= sat_event; IDLE/ACCUM -> ACCUM.
  - Frame close: an accept with prod_last_i=1, or the accept that brings count to MAX_TERMS.
    - Apply the same update, then go to HOLD.
    - Next cycle: acc_valid_o=1, acc_o = updated acc, term_cnt_o = updated count, ovf_o = updated flag.
  - HOLD: acc_o, term_cnt_o and ovf_o are stable; no products are accepted.
    - On acc_valid_o && acc_ready_i: clear acc, count and ovf; go to IDLE.
    - The first product of the next frame is accepted no earlier than the following cycle.
- Latency: 1 cycle from the closing accept edge to acc_valid_o.
  - Throughput: one product per cycle. Minimum gap between frames is 1 HOLD cycle.
- Saturation:
  - The sum is computed at ACC_W+1 bits.
  - Above 2^(ACC_W-1)-1, clamp to max positive; below -2^(ACC_W-1), clamp to min negative.
  - sat_event=1 on either clamp.
  - With the default ACC_W=20 and 8x8 operands, saturation is unreachable. The logic must still exist for overridden widths.
- ce_i=0: no accepts, internal state frozen. The HOLD output handshake still completes, independent of ce_i.
- prod_valid_i while in HOLD: ignored, not consumed. The upstream must hold the product.
- prod_last_i is ignored unless an accept occurs.
- Reset mid-frame or mid-HOLD: the partial or presented result is discarded; all outputs return to reset values immediately.

Decomposition:
- Package booth_mac_pkg holds:
  - the state enum (IDLE, ACCUM, HOLD)
  - default widths PROD_W=16, ACC_W=20, MAX_TERMS=16
  - a CNT_W localparam
- One natural sub-module: booth_sat_add.
  - Combinational signed saturating adder (ACC_W accumulator + sign-extended PROD_W addend).
  - Outputs: clamped sum and sat flag.

Test Plan:
- Single term: prod_i=16'h05E8 (0x54*0x12) with last=1 -> next cycle acc_valid_o=1, acc_o=20'h005E8, term_cnt_o=1, ovf_o=0.
- Signed mix: 16'h05E8, 16'hFFF0, 16'h0010(last) on consecutive cycles -> acc_o=20'h005E8, term_cnt_o=3.
- Negative result: 16'hC000 (-16384) twice, last on the 2nd -> acc_o=20'hF8000, term_cnt_o=2.
- Saturation (ACC_W=18): 8 x 16'h4000, last on the 8th -> acc_o=18'h1FFFF, ovf_o=1.
  - Next frame 16'h0001(last) -> acc_o=1, ovf_o=0.
- Backpressure and auto-close: 16 x 16'h0001 with last=0 -> closes after the 16th, acc_o=16, term_cnt_o=16.
  - Hold acc_ready_i=0 for 3 cycles -> acc_o stable, prod_ready_o=0, offered 17th product not consumed.
  - Then ready=1 -> IDLE, 17th product accepted the cycle after.
- Reset and ce_i: 3 products accepted, then rst_ni low mid-frame -> all outputs 0 immediately. After release, 16'h0002(last) -> acc_o=2.
  - With ce_i=0 and prod_valid_i=1 -> prod_ready_o=0, no state change.

Source files
------------

// File: rtl/booth_mac_pkg.sv
// Shared definitions for the Booth MAC accumulator.
//   - default widths for product, accumulator and frame length
//   - frame state enum used by booth_mac_accum
//   - helper to size the term counter for a given frame length
package booth_mac_pkg;

    localparam int unsigned DEF_PROD_W    = 16;
    localparam int unsigned DEF_ACC_W     = 20;
    localparam int unsigned DEF_MAX_TERMS = 16;
    localparam int unsigned CNT_W         = $clog2(DEF_MAX_TERMS + 1);

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StHold
    } state_e;

    // Counter must be able to hold MAX_TERMS itself, not just MAX_TERMS-1.
    function automatic int unsigned cnt_width(input int unsigned max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational signed saturating adder.
//   acc_i    : ACC_W signed accumulator value
//   addend_i : PROD_W signed addend, sign-extended to the accumulator width
//   sum_o    : acc_i + addend_i clamped to the ACC_W signed range
//   sat_o    : high when the clamp was applied
module booth_sat_add #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 20
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] addend_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sat_o
);

    logic [ACC_W:0] w_acc_ext;
    logic [ACC_W:0] w_add_ext;
    logic [ACC_W:0] w_sum;

    assign w_acc_ext = {acc_i[ACC_W-1], acc_i};
    assign w_add_ext = {{(ACC_W + 1 - PROD_W){addend_i[PROD_W-1]}}, addend_i};
    assign w_sum     = w_acc_ext + w_add_ext;

    // One guard bit suffices: overflow iff the guard bit disagrees with the
    // ACC_W sign bit; the guard bit then gives the true sign of the result.
    always_comb begin
        sat_o = 1'b0;
        sum_o = w_sum[ACC_W-1:0];
        if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
            sat_o = 1'b1;
            if (w_sum[ACC_W]) begin
                sum_o = {1'b1, {(ACC_W - 1){1'b0}}};
            end else begin
                sum_o = {1'b0, {(ACC_W - 1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/booth_mac_accum.sv
// Frame accumulator for signed Booth products with saturating arithmetic.
//   clk_i, rst_ni          : clock, async active-low reset
//   ce_i                   : clock enable, gates product acceptance only
//   prod_i/prod_valid_i/
//   prod_last_i/prod_ready_o : product input stream
//   acc_o/acc_valid_o/
//   acc_ready_i            : per-frame result, held until accepted
//   term_cnt_o             : products in the presented frame
//   ovf_o                  : saturation happened somewhere in the frame
module booth_mac_accum
    import booth_mac_pkg::*;
#(
    parameter int unsigned  PROD_W    = DEF_PROD_W,
    parameter int unsigned  ACC_W     = DEF_ACC_W,
    parameter int unsigned  MAX_TERMS = DEF_MAX_TERMS,
    localparam int unsigned TCNT_W    = cnt_width(MAX_TERMS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ce_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    input  logic              prod_last_i,
    output logic              prod_ready_o,
    output logic [ACC_W-1:0]  acc_o,
    output logic              acc_valid_o,
    input  logic              acc_ready_i,
    output logic [TCNT_W-1:0] term_cnt_o,
    output logic              ovf_o
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic [TCNT_W-1:0] r_cnt;
    logic [TCNT_W-1:0] w_cnt_nxt;
    logic              r_ovf;
    logic              w_ovf_nxt;

    logic [ACC_W-1:0]  w_sum;
    logic              w_sat;
    logic              w_accept;
    logic              w_close;

    booth_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .acc_i    (r_acc),
        .addend_i (prod_i),
        .sum_o    (w_sum),
        .sat_o    (w_sat)
    );

    assign prod_ready_o = ce_i && (r_state != StHold);
    assign w_accept     = prod_valid_i && prod_ready_o;
    // Reaching MAX_TERMS closes the frame even without last.
    assign w_close      = prod_last_i || (r_cnt == TCNT_W'(MAX_TERMS - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        unique case (r_state)
            StHold: begin
                // Output handshake deliberately ignores ce_i.
                if (acc_ready_i) begin
                    w_state_nxt = StIdle;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            default: begin
                if (w_accept) begin
                    w_acc_nxt   = w_sum;
                    w_cnt_nxt   = r_cnt + TCNT_W'(1);
                    w_ovf_nxt   = r_ovf | w_sat;
                    w_state_nxt = w_close ? StHold : StAccum;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign acc_valid_o = (r_state == StHold);
    assign acc_o       = r_acc;
    assign term_cnt_o  = r_cnt;
    assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_booth_mac_accum.sv
// Self-checking bench for booth_mac_accum: a default-width instance and an
// ACC_W=18 instance share one stimulus stream and are checked against a
// frame-level arithmetic model plus directed constant expectations.
module tb_booth_mac_accum;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ce_i;
    logic [15:0] prod_i;
    logic        prod_valid_i;
    logic        prod_last_i;
    logic        acc_ready_i;

    logic        ready20, valid20, ovf20;
    logic [19:0] acc20;
    logic [4:0]  cnt20;
    logic        ready18, valid18, ovf18;
    logic [17:0] acc18;
    logic [4:0]  cnt18;

    int n_checks = 0;
    int n_errors = 0;

    // Model: frame-level view, one accumulator per instance width.
    longint m_acc [2];
    bit     m_ovf [2];
    int     m_cnt;
    bit     m_hold;
    int     m_width [2] = '{20, 18};

    always #5 clk_i = ~clk_i;

    booth_mac_accum dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ce_i         (ce_i),
        .prod_i       (prod_i),
        .prod_valid_i (prod_valid_i),
        .prod_last_i  (prod_last_i),
        .prod_ready_o (ready20),
        .acc_o        (acc20),
        .acc_valid_o  (valid20),
        .acc_ready_i  (acc_ready_i),
        .term_cnt_o   (cnt20),
        .ovf_o        (ovf20)
    );

    booth_mac_accum #(.ACC_W(18)) dut18 (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .ce_i         (ce_i),
        .prod_i       (prod_i),
        .prod_valid_i (prod_valid_i),
        .prod_last_i  (prod_last_i),
        .prod_ready_o (ready18),
        .acc_o        (acc18),
        .acc_valid_o  (valid18),
        .acc_ready_i  (acc_ready_i),
        .term_cnt_o   (cnt18),
        .ovf_o        (ovf18)
    );

    typedef struct {
        bit          valid;
        bit          last;
        logic [15:0] prod;
        bit          ready;
        bit          chk;
        logic [19:0] exp_acc;
        int          exp_cnt;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint clamp(input longint s, input int w, output bit f);
        longint hi = (64'sd1 <<< (w - 1)) - 1;
        longint lo = -(64'sd1 <<< (w - 1));
        f = 1'b0;
        if (s > hi) begin
            f = 1'b1;
            return hi;
        end
        if (s < lo) begin
            f = 1'b1;
            return lo;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_acc  = '{0, 0};
        m_ovf  = '{0, 0};
        m_cnt  = 0;
        m_hold = 0;
    endtask

    // Drive inputs just after an edge, then compare DUT against the model.
    task automatic drive(input bit v, input bit l, input logic [15:0] p,
                         input bit c, input bit r);
        prod_valid_i = v;
        prod_last_i  = l;
        prod_i       = p;
        ce_i         = c;
        acc_ready_i  = r;
        #4;
        chk("prod_ready", ready20, c && !m_hold);
        chk("prod_ready18", ready18, c && !m_hold);
        chk("acc_valid", valid20, m_hold);
        if (m_hold) begin
            chk("acc", $signed(acc20), m_acc[0]);
            chk("acc18", $signed(acc18), m_acc[1]);
            chk("term_cnt", cnt20, m_cnt);
            chk("ovf", ovf20, m_ovf[0]);
            chk("ovf18", ovf18, m_ovf[1]);
        end
    endtask

    // Advance the model with the driven inputs and cross the clock edge.
    task automatic edge_step();
        bit f;
        if (m_hold) begin
            if (acc_ready_i) model_reset();
        end else if (ce_i && prod_valid_i) begin
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = clamp(m_acc[k] + longint'($signed(prod_i)), m_width[k], f);
                m_ovf[k] = m_ovf[k] | f;
            end
            m_cnt++;
            if (prod_last_i || m_cnt == 16) m_hold = 1;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic step(input bit v, input bit l, input logic [15:0] p,
                        input bit c, input bit r);
        drive(v, l, p, c, r);
        edge_step();
    endtask

    vec_t vecs [9];

    initial begin
        vecs[0] = '{1, 1, 16'h05E8, 0, 0, 20'h0,     0};
        vecs[1] = '{0, 0, 16'h0000, 1, 1, 20'h005E8, 1};
        vecs[2] = '{1, 0, 16'h05E8, 0, 0, 20'h0,     0};
        vecs[3] = '{1, 0, 16'hFFF0, 0, 0, 20'h0,     0};
        vecs[4] = '{1, 1, 16'h0010, 0, 0, 20'h0,     0};
        vecs[5] = '{0, 0, 16'h0000, 1, 1, 20'h005E8, 3};
        vecs[6] = '{1, 0, 16'hC000, 0, 0, 20'h0,     0};
        vecs[7] = '{1, 1, 16'hC000, 0, 0, 20'h0,     0};
        vecs[8] = '{0, 0, 16'h0000, 1, 1, 20'hF8000, 2};

        rst_ni = 1'b0;
        ce_i = 1'b1; prod_i = '0; prod_valid_i = 1'b0; prod_last_i = 1'b0;
        acc_ready_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        chk("rst_acc", acc20, 0);
        chk("rst_valid", acc_valid_i_dummy(), 0);
        chk("rst_cnt", cnt20, 0);
        chk("rst_ovf", ovf20, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed frames from the table.
        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].last, vecs[i].prod, 1'b1, vecs[i].ready);
            if (vecs[i].chk) begin
                chk("tbl_valid", valid20, 1);
                chk("tbl_acc", $signed(acc20), $signed(vecs[i].exp_acc));
                chk("tbl_cnt", cnt20, vecs[i].exp_cnt);
                chk("tbl_ovf", ovf20, 0);
            end
            edge_step();
        end

        // Saturation on the narrow instance, then a clean frame.
        for (int i = 0; i < 8; i++) step(1, i == 7, 16'h4000, 1, 0);
        drive(0, 0, 16'h0, 1, 1);
        chk("sat_acc18", acc18, 18'h1FFFF);
        chk("sat_ovf18", ovf18, 1);
        chk("sat_acc20", acc20, 20'h20000);
        chk("sat_ovf20", ovf20, 0);
        edge_step();
        step(1, 1, 16'h0001, 1, 0);
        drive(0, 0, 16'h0, 1, 1);
        chk("post_sat_acc18", acc18, 1);
        chk("post_sat_ovf18", ovf18, 0);
        edge_step();

        // Auto-close at MAX_TERMS with backpressure on the result.
        for (int i = 0; i < 16; i++) step(1, 0, 16'h0001, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 16'h0007, 1, 0);
            chk("auto_acc", acc20, 16);
            chk("auto_cnt", cnt20, 16);
            chk("hold_ready", ready20, 0);
            edge_step();
        end
        step(1, 1, 16'h0007, 1, 1);
        drive(1, 1, 16'h0007, 1, 0);
        chk("after_rel_ready", ready20, 1);
        chk("after_rel_valid", valid20, 0);
        edge_step();
        drive(0, 0, 16'h0, 1, 1);
        chk("17th_acc", acc20, 7);
        chk("17th_cnt", cnt20, 1);
        edge_step();

        // Asynchronous reset mid-frame.
        for (int i = 0; i < 3; i++) step(1, 0, 16'h0100, 1, 0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_acc", acc20, 0);
        chk("mid_rst_cnt", cnt20, 0);
        chk("mid_rst_acc18", acc18, 0);
        model_reset();
        prod_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        step(1, 1, 16'h0002, 1, 0);
        drive(0, 0, 16'h0, 1, 1);
        chk("after_rst_acc", acc20, 2);
        chk("after_rst_cnt", cnt20, 1);
        edge_step();

        // Clock enable low: nothing is taken.
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 16'h0005, 0, 0);
            chk("ce_low_ready", ready20, 0);
            edge_step();
        end
        step(1, 1, 16'h0003, 1, 0);
        drive(0, 0, 16'h0, 0, 1);
        chk("ce_acc", acc20, 3);
        chk("ce_cnt", cnt20, 1);
        edge_step();
        drive(0, 0, 16'h0, 1, 0);
        chk("ce_low_release", valid20, 0);
        edge_step();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [15:0] p;
            p = ($urandom_range(0, 3) == 0) ? 16'(($urandom_range(0, 1) == 0) ? 16'h7FFF : 16'h8000)
                                            : 16'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, p,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    function automatic logic acc_valid_i_dummy();
        return valid20;
    endfunction

endmodule
